// File: rtl/tau_exec_pkg.sv
// Shared types and constants for the execution controller and its watchdog.
package tau_exec_pkg;

    typedef enum logic [2:0] {
        BOOT,
        LOAD,
        DECODE,
        EXEC,
        ADVANCE,
        PAUSE,
        HALTED,
        FAULT
    } state_t;

    localparam int HALT_IMMEDIATE = 0;
    localparam int HALT_BOUNDARY  = 1;

    typedef struct packed {
        logic load_n;
        logic seq_enable;
        logic rom_read;
        logic pc_enable;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        load_n:     1'b1,
        seq_enable: 1'b0,
        rom_read:   1'b0,
        pc_enable:  1'b0
    };

    // Control lines are fully determined by the state being entered.
    function automatic ctrl_t ctrl_for(state_t s);
        ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            DECODE: begin
                c.load_n   = 1'b0;
                c.rom_read = 1'b1;
            end
            EXEC: begin
                c.seq_enable = 1'b1;
                c.rom_read   = 1'b1;
            end
            ADVANCE: c.pc_enable = 1'b1;
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/exec_uop_watchdog.sv
// Counts EXEC cycles of the current instruction and flags when MAX_UOPS is reached.
module exec_uop_watchdog #(
    parameter int unsigned MAX_UOPS = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic increment,
    input  logic clear,
    output logic limit_hit
);

    localparam int unsigned CNT_W = $clog2(MAX_UOPS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_UOPS);

    logic [CNT_W-1:0] uop_cnt;

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(negedge clock) begin
        if (reset || clear) begin
            uop_cnt <= '0;
        end else if (load) begin
            uop_cnt <= CNT_W'(1);
        end else if (increment && uop_cnt != CNT_MAX) begin
            uop_cnt <= uop_cnt + CNT_W'(1);
        end
    end

    assign limit_hit = (uop_cnt == CNT_MAX);

endmodule

// File: rtl/execution_controller.sv
// Sequences each instruction through opcode load, microcode execution and PC advance,
// with halt/resume, single-step, a micro-op watchdog and a retired-instruction counter.
module execution_controller
    import tau_exec_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 1,
    parameter int unsigned MAX_UOPS    = 16,
    parameter int          HALT_MODE   = HALT_IMMEDIATE,
    parameter int unsigned COUNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               instruction_finish_control_line,
    input  logic               halt,
    input  logic               resume,
    input  logic               step_mode,
    input  logic               step,
    output logic               microcode_sequencer_load_n,
    output logic               microcode_sequencer_enable,
    output logic               microcode_rom_read_enable,
    output logic               program_counter_enable,
    output logic               halted,
    output logic               fault,
    output logic [COUNT_W-1:0] retired_count
);

    localparam int unsigned BOOT_W = $clog2(BOOT_CYCLES + 1);
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    ctrl_t             ctrl;
    ctrl_t             ctrl_next;
    logic [BOOT_W-1:0] boot_cnt;
    logic              halt_pending;
    logic              halt_req;
    logic              abort;
    logic              entering_halt;
    logic              limit_hit;
    logic              wd_load;
    logic              wd_increment;
    logic              wd_clear;

    // A raw halt request also counts in boundary mode, so a halt seen in ADVANCE is not missed.
    assign halt_req      = halt || halt_pending;
    assign abort         = (HALT_MODE == HALT_IMMEDIATE) && halt;
    assign entering_halt = (state_next == HALTED) && (state != HALTED);

    always_ff @(negedge clock) begin
        if (reset) begin
            state <= BOOT;
            ctrl  <= CTRL_IDLE;
        end else begin
            state <= state_next;
            ctrl  <= ctrl_next;
        end
    end

    always_comb begin
        // NOTE: defaulting to the current state first keeps every path assigned, so no latch.
        state_next = state;
        case (state)
            BOOT: begin
                if (halt_req) begin
                    state_next = HALTED;
                end else if (enable && boot_cnt == BOOT_LAST) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = HALTED;
                end else if (enable) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (abort) begin
                    state_next = HALTED;
                end else if (enable) begin
                    state_next = instruction_finish_control_line ? ADVANCE : EXEC;
                end
            end
            EXEC: begin
                if (abort) begin
                    state_next = HALTED;
                end else if (enable) begin
                    if (instruction_finish_control_line) begin
                        state_next = ADVANCE;
                    end else if (limit_hit) begin
                        state_next = FAULT;
                    end
                end
            end
            ADVANCE: begin
                if (enable) begin
                    if (halt_req) begin
                        state_next = HALTED;
                    end else if (step_mode) begin
                        state_next = PAUSE;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            PAUSE: begin
                if (halt_req) begin
                    state_next = HALTED;
                end else if (enable && step) begin
                    state_next = LOAD;
                end
            end
            HALTED: begin
                if (resume && !halt) begin
                    state_next = LOAD;
                end
            end
            FAULT:   state_next = FAULT;
            default: state_next = BOOT;
        endcase
    end

    // Outputs are registered copies of the controls belonging to the next state.
    always_comb begin
        ctrl_next = ctrl_for(state_next);
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            boot_cnt      <= '0;
            halt_pending  <= 1'b0;
            retired_count <= '0;
        end else begin
            if (enable && state == BOOT && state_next == BOOT) begin
                boot_cnt <= boot_cnt + BOOT_W'(1);
            end
            if (entering_halt) begin
                halt_pending <= 1'b0;
            end else if (HALT_MODE == HALT_BOUNDARY && halt &&
                         state != HALTED && state != FAULT) begin
                halt_pending <= 1'b1;
            end
            if (enable && state == ADVANCE) begin
                retired_count <= retired_count + COUNT_W'(1);
            end
        end
    end

    assign wd_load      = (state != EXEC) && (state_next == EXEC);
    assign wd_increment = enable && (state == EXEC) && (state_next == EXEC);
    assign wd_clear     = (state_next != EXEC);

    exec_uop_watchdog #(
        .MAX_UOPS (MAX_UOPS)
    ) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .load      (wd_load),
        .increment (wd_increment),
        .clear     (wd_clear),
        .limit_hit (limit_hit)
    );

    assign microcode_sequencer_load_n = ctrl.load_n;
    assign microcode_sequencer_enable = ctrl.seq_enable;
    assign microcode_rom_read_enable  = ctrl.rom_read;
    assign program_counter_enable     = ctrl.pc_enable;
    assign halted                     = (state == HALTED);
    assign fault                      = (state == FAULT);

endmodule

// File: tb/tb_execution_controller.sv
// Self-checking bench: per-cycle expectations are built from instruction-level schedules
// (phase sequence per instruction) and compared against three differently configured DUTs.
module tb_execution_controller;

    typedef enum int {P_BOOT, P_LOAD, P_DECODE, P_EXEC, P_ADVANCE, P_PAUSE, P_HALTED, P_FAULT} phase_t;

    typedef struct {
        phase_t ph;
        int     ret;
        logic   fin;
        logic   hlt;
        logic   res;
        logic   stp;
        logic   stm;
        logic   en;
    } cyc_t;

    localparam int DUT_IMM = 0;
    localparam int DUT_BND = 1;
    localparam int DUT_WDG = 2;

    logic clock     = 1'b0;
    logic reset     = 1'b1;
    logic enable    = 1'b1;
    logic finish    = 1'b0;
    logic halt      = 1'b0;
    logic resume    = 1'b0;
    logic step_mode = 1'b0;
    logic step      = 1'b0;

    logic        imm_load_n, imm_seq, imm_rom, imm_pc, imm_halted, imm_fault;
    logic [15:0] imm_ret;
    logic        bnd_load_n, bnd_seq, bnd_rom, bnd_pc, bnd_halted, bnd_fault;
    logic [2:0]  bnd_ret;
    logic        wdg_load_n, wdg_seq, wdg_rom, wdg_pc, wdg_halted, wdg_fault;
    logic [15:0] wdg_ret;

    int   n_checks = 0;
    int   n_errors = 0;
    cyc_t sched[$];
    int   m_ret = 0;
    logic cur_stm = 1'b0;

    always #5 clock = ~clock;

    execution_controller #(.BOOT_CYCLES(1), .MAX_UOPS(16), .HALT_MODE(0), .COUNT_W(16)) u_imm (
        .clock(clock), .reset(reset), .enable(enable),
        .instruction_finish_control_line(finish), .halt(halt), .resume(resume),
        .step_mode(step_mode), .step(step),
        .microcode_sequencer_load_n(imm_load_n), .microcode_sequencer_enable(imm_seq),
        .microcode_rom_read_enable(imm_rom), .program_counter_enable(imm_pc),
        .halted(imm_halted), .fault(imm_fault), .retired_count(imm_ret)
    );

    execution_controller #(.BOOT_CYCLES(1), .MAX_UOPS(16), .HALT_MODE(1), .COUNT_W(3)) u_bnd (
        .clock(clock), .reset(reset), .enable(enable),
        .instruction_finish_control_line(finish), .halt(halt), .resume(resume),
        .step_mode(step_mode), .step(step),
        .microcode_sequencer_load_n(bnd_load_n), .microcode_sequencer_enable(bnd_seq),
        .microcode_rom_read_enable(bnd_rom), .program_counter_enable(bnd_pc),
        .halted(bnd_halted), .fault(bnd_fault), .retired_count(bnd_ret)
    );

    execution_controller #(.BOOT_CYCLES(3), .MAX_UOPS(4), .HALT_MODE(0), .COUNT_W(16)) u_wdg (
        .clock(clock), .reset(reset), .enable(enable),
        .instruction_finish_control_line(finish), .halt(halt), .resume(resume),
        .step_mode(step_mode), .step(step),
        .microcode_sequencer_load_n(wdg_load_n), .microcode_sequencer_enable(wdg_seq),
        .microcode_rom_read_enable(wdg_rom), .program_counter_enable(wdg_pc),
        .halted(wdg_halted), .fault(wdg_fault), .retired_count(wdg_ret)
    );

    // {load_n, seq_enable, rom_read, pc_enable, halted, fault} seen during each phase
    function automatic logic [5:0] exp_of(phase_t ph);
        case (ph)
            P_DECODE:  return 6'b001000;
            P_EXEC:    return 6'b111000;
            P_ADVANCE: return 6'b100100;
            P_HALTED:  return 6'b100010;
            P_FAULT:   return 6'b100001;
            default:   return 6'b100000;
        endcase
    endfunction

    function automatic logic [5:0] obs_of(int d);
        case (d)
            DUT_IMM: return {imm_load_n, imm_seq, imm_rom, imm_pc, imm_halted, imm_fault};
            DUT_BND: return {bnd_load_n, bnd_seq, bnd_rom, bnd_pc, bnd_halted, bnd_fault};
            default: return {wdg_load_n, wdg_seq, wdg_rom, wdg_pc, wdg_halted, wdg_fault};
        endcase
    endfunction

    function automatic logic [15:0] ret_of(int d);
        case (d)
            DUT_IMM: return imm_ret;
            DUT_BND: return {13'd0, bnd_ret};
            default: return wdg_ret;
        endcase
    endfunction

    function automatic logic [15:0] ret_exp(int d, int r);
        if (d == DUT_BND) return 16'(r % 8);
        return 16'(r % 65536);
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input phase_t ph, input logic fin, input logic hlt = 1'b0,
                        input logic res = 1'b0, input logic stp = 1'b0, input logic en = 1'b1);
        cyc_t c;
        c.ph  = ph;
        c.ret = m_ret;
        c.fin = fin;
        c.hlt = hlt;
        c.res = res;
        c.stp = stp;
        c.stm = cur_stm;
        c.en  = en;
        sched.push_back(c);
    endtask

    task automatic maybe_freeze(input phase_t ph, input bit allow);
        if (allow && $urandom_range(0, 5) == 0) push(ph, rbit(), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One instruction with k EXEC cycles (k=0: short); finish is only meaningful in DECODE/EXEC.
    task automatic push_instr(input int k, input logic adv_halt, input bit allow_freeze);
        maybe_freeze(P_LOAD, allow_freeze);
        push(P_LOAD, rbit());
        maybe_freeze(P_DECODE, allow_freeze);
        push(P_DECODE, 1'(k == 0));
        for (int i = 1; i <= k; i++) begin
            maybe_freeze(P_EXEC, allow_freeze);
            push(P_EXEC, 1'(i == k));
        end
        push(P_ADVANCE, rbit(), adv_halt);
        m_ret++;
    endtask

    task automatic run_sched(input int mask, input string tag);
        foreach (sched[i]) begin
            @(posedge clock);
            for (int d = 0; d < 3; d++) begin
                if (mask[d]) begin
                    n_checks++;
                    if (obs_of(d) !== exp_of(sched[i].ph)) begin
                        n_errors++;
                        $display("FAIL %s dut%0d cycle %0d controls/status: got %b expected %b",
                                 tag, d, i, obs_of(d), exp_of(sched[i].ph));
                    end
                    n_checks++;
                    if (ret_of(d) !== ret_exp(d, sched[i].ret)) begin
                        n_errors++;
                        $display("FAIL %s dut%0d cycle %0d retired_count: got %0d expected %0d",
                                 tag, d, i, ret_of(d), ret_exp(d, sched[i].ret));
                    end
                end
            end
            finish    = sched[i].fin;
            halt      = sched[i].hlt;
            resume    = sched[i].res;
            step      = sched[i].stp;
            step_mode = sched[i].stm;
            enable    = sched[i].en;
        end
        sched.delete();
    endtask

    // Applies reset for one falling edge and checks reset values on all DUTs in the BOOT cycle.
    task automatic do_reset(input string tag);
        @(posedge clock);
        reset = 1'b1; enable = 1'b1; finish = 1'b0; halt = 1'b0;
        resume = 1'b0; step = 1'b0; step_mode = 1'b0;
        @(posedge clock);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (obs_of(d) !== 6'b100000 || ret_of(d) !== 16'd0) begin
                n_errors++;
                $display("FAIL %s dut%0d reset values: got ctrl %b count %0d expected ctrl 100000 count 0",
                         tag, d, obs_of(d), ret_of(d));
            end
        end
        reset   = 1'b0;
        m_ret   = 0;
        cur_stm = 1'b0;
    endtask

    task automatic test_reset();
        do_reset("reset_initial");
        push_instr(2, 1'b0, 1'b0);
        push(P_LOAD, 1'b0);
        run_sched(1, "reset_pre");
        do_reset("reset_mid_run");
    endtask

    task automatic test_stream();
        int ks[$];
        do_reset("stream");
        ks = '{0, 0, 0, 0, 5};
        foreach (ks[i]) push_instr(ks[i], 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) push_instr(int'($urandom_range(0, 8)), 1'b0, 1'b1);
        push(P_LOAD, 1'b0);
        run_sched(3, "stream");
    endtask

    task automatic test_watchdog();
        do_reset("wdg");
        push(P_BOOT, rbit());
        push(P_BOOT, rbit());
        push_instr(4, 1'b0, 1'b0);
        push_instr(1, 1'b0, 1'b0);
        push(P_LOAD, rbit());
        push(P_DECODE, 1'b0);
        push(P_EXEC, 1'b0);
        push(P_EXEC, 1'b0);
        for (int i = 0; i < 3; i++) push(P_EXEC, rbit(), 1'b0, 1'b0, 1'b0, 1'b0);
        push(P_EXEC, 1'b0);
        push(P_EXEC, 1'b1);
        push(P_ADVANCE, rbit());
        m_ret++;
        push(P_LOAD, rbit());
        push(P_DECODE, 1'b0);
        for (int i = 0; i < 4; i++) push(P_EXEC, 1'b0);
        push(P_FAULT, 1'b0, 1'b0, 1'b1);
        push(P_FAULT, 1'b0, 1'b1, 1'b0);
        push(P_FAULT, 1'b0, 1'b0, 1'b1);
        push(P_FAULT, 1'b1);
        push(P_FAULT, 1'b0);
        run_sched(4, "wdg");
        do_reset("wdg_reset_clears_fault");
    endtask

    task automatic test_halt_immediate();
        do_reset("halt_imm");
        push(P_LOAD, rbit());
        push(P_DECODE, 1'b0);
        push(P_EXEC, 1'b0);
        push(P_EXEC, 1'b0, 1'b1);
        push(P_HALTED, rbit());
        push(P_HALTED, rbit(), 1'b1, 1'b1);
        push(P_HALTED, rbit());
        push(P_HALTED, rbit(), 1'b0, 1'b1);
        push_instr(5, 1'b1, 1'b0);
        push(P_HALTED, rbit());
        push(P_HALTED, rbit(), 1'b0, 1'b1);
        push(P_LOAD, 1'b0);
        run_sched(1, "halt_imm");
    endtask

    task automatic test_halt_boundary();
        do_reset("halt_bnd");
        push(P_LOAD, rbit());
        push(P_DECODE, 1'b0);
        push(P_EXEC, 1'b0);
        push(P_EXEC, 1'b0, 1'b1);
        push(P_EXEC, 1'b0);
        push(P_EXEC, 1'b0);
        push(P_EXEC, 1'b1);
        push(P_ADVANCE, rbit());
        m_ret++;
        push(P_HALTED, rbit());
        push(P_HALTED, rbit(), 1'b1, 1'b1);
        push(P_HALTED, rbit(), 1'b0, 1'b1);
        push_instr(0, 1'b0, 1'b0);
        push(P_LOAD, 1'b0);
        run_sched(2, "halt_bnd");
    endtask

    task automatic test_step();
        do_reset("step");
        cur_stm = 1'b1;
        for (int j = 0; j < 3; j++) begin
            push_instr(int'($urandom_range(0, 4)), 1'b0, 1'b0);
            for (int p = 0; p < 9; p++) push(P_PAUSE, rbit());
            push(P_PAUSE, rbit(), 1'b0, 1'b0, 1'b1);
        end
        push_instr(int'($urandom_range(0, 4)), 1'b0, 1'b0);
        push(P_PAUSE, rbit());
        push(P_PAUSE, rbit());
        push(P_PAUSE, rbit(), 1'b1, 1'b0, 1'b1);
        push(P_HALTED, rbit());
        push(P_HALTED, rbit(), 1'b0, 1'b1);
        push_instr(0, 1'b0, 1'b0);
        push(P_PAUSE, 1'b0);
        push(P_PAUSE, 1'b0);
        run_sched(1, "step");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_watchdog();
        test_halt_immediate();
        test_halt_boundary();
        test_step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
